// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: shared types, byte width and sizing helpers for the byte packer
package byte_packer_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {EMPTY, PARTIAL} pk_state_e;
    function automatic int bytes_per_word(int width);
        return width / BYTE_W;
    endfunction
    function automatic int cnt_w(int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/byte_packer_if.sv
// byte_packer_if: byte input strobe plus valid/ready word output of the packer
interface byte_packer_if import byte_packer_pkg::*; #(parameter int WIDTH = 32);
    localparam int CW = cnt_w(bytes_per_word(WIDTH));
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [CW-1:0]     out_bytes;
    modport master (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_bytes
    );
    modport slave (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_bytes
    );
endinterface

// File: rtl/byte_packer_fifo.sv
// packer_fifo: synchronous show-ahead FIFO; head reads as zero while empty
module packer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr, rd;
    logic          do_push, do_pop;
    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push writes into
    assign do_push = push && (!full || do_pop);
    assign level   = wr - rd;
    assign dout    = empty ? '0 : mem[rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/byte_packer.sv
// byte_packer: assembles a byte stream into little-endian words queued in a FIFO
module byte_packer import byte_packer_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    byte_packer_if.master          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int N  = bytes_per_word(WIDTH);
    localparam int IW = $clog2(N);
    localparam int CW = cnt_w(N);
    pk_state_e         state, state_n;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  word, asm;
    logic [CW-1:0]     cnt;
    logic              byte_in, push, pop, full, empty;
    logic [WIDTH+CW-1:0] head;
    always_comb begin
        byte_in = bus.in_valid;
        asm     = byte_in ? word | (WIDTH'(bus.in_data) << {idx, 3'b000}) : word;
        cnt     = CW'(idx) + CW'(byte_in);
        push    = (byte_in && idx == IW'(N - 1)) || (bus.flush && (state == PARTIAL || byte_in));
        state_n = push ? EMPTY : byte_in ? PARTIAL : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            idx   <= push ? '0 : idx + IW'(byte_in);
            word  <= push ? '0 : asm;
        end
    end
    assign pop = bus.out_ready && !empty;
    always_ff @(posedge clk) begin
        if (rst) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end
    packer_fifo #(.DW(WIDTH + CW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.out_ready),
        .din   ({cnt, asm}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    assign bus.out_valid = !empty;
    assign {bus.out_bytes, bus.out_data} = head;
endmodule
